// File: rtl/jtsdram_rdarb.sv
// Round-robin arbiter sharing one SDRAM read port among four bank checker channels.
// Serialises reads, routes ack/rdy to the winner, latches data and watches for rdy timeouts.
module jtsdram_rdarb #(
  parameter int TOUT_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [21:0]       ba0_addr,
  input  logic [21:0]       ba1_addr,
  input  logic [21:0]       ba2_addr,
  input  logic [21:0]       ba3_addr,
  input  logic              ba0_rd,
  input  logic              ba1_rd,
  input  logic              ba2_rd,
  input  logic              ba3_rd,
  output logic              ba0_ack,
  output logic              ba1_ack,
  output logic              ba2_ack,
  output logic              ba3_ack,
  output logic              ba0_rdy,
  output logic              ba1_rdy,
  output logic              ba2_rdy,
  output logic              ba3_rdy,
  output logic [21:0]       sdram_addr,
  output logic [1:0]        sdram_ba,
  output logic              sdram_rd,
  input  logic              sdram_ack,
  input  logic              sdram_rdy,
  input  logic [31:0]       sdram_dout,
  output logic [31:0]       data_read,
  input  logic              rfsh_req,
  output logic              rfsh_ok,
  output logic              timeout,
  output logic [CNT_W-1:0]  rd_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  // Last counter value before all-ones: firing here makes the timeout
  // land after 2^TOUT_W-1 cycles spent in WAIT.
  localparam logic [TOUT_W-1:0] TOUT_LAST = ~TOUT_W'(1);

  state_t            state;
  logic [1:0]        ptr;
  logic [1:0]        gnt;
  logic [3:0]        ack;
  logic [3:0]        rdy;
  logic [TOUT_W-1:0] tcnt;
  logic [3:0]        rd_vec;
  logic [21:0]       addr_arr [4];
  logic [2:0]        pick;

  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] base);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    idx = base;
    // Walk from the farthest slot back to base so the nearest request wins.
    for (int i = 3; i >= 0; i--) begin
      idx = base + 2'(i);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign rd_vec      = {ba3_rd, ba2_rd, ba1_rd, ba0_rd};
  assign addr_arr[0] = ba0_addr;
  assign addr_arr[1] = ba1_addr;
  assign addr_arr[2] = ba2_addr;
  assign addr_arr[3] = ba3_addr;
  assign pick        = rr_pick(rd_vec, ptr);

  assign ba0_ack = ack[0];
  assign ba1_ack = ack[1];
  assign ba2_ack = ack[2];
  assign ba3_ack = ack[3];
  assign ba0_rdy = rdy[0];
  assign ba1_rdy = rdy[1];
  assign ba2_rdy = rdy[2];
  assign ba3_rdy = rdy[3];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ptr        <= 2'd0;
      gnt        <= 2'd0;
      ack        <= 4'd0;
      rdy        <= 4'd0;
      tcnt       <= '0;
      sdram_rd   <= 1'b0;
      sdram_addr <= 22'd0;
      sdram_ba   <= 2'd0;
      data_read  <= 32'd0;
      rfsh_ok    <= 1'b0;
      timeout    <= 1'b0;
      rd_cnt     <= '0;
    end else begin
      ack     <= 4'd0;
      rdy     <= 4'd0;
      rfsh_ok <= (state == IDLE) && rfsh_req;
      case (state)
        IDLE: begin
          if (!rfsh_req && pick[2]) begin
            gnt        <= pick[1:0];
            sdram_addr <= addr_arr[pick[1:0]];
            sdram_ba   <= pick[1:0];
            sdram_rd   <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          // An ack arriving with the rd drop still counts: the controller took it.
          if (sdram_ack) begin
            sdram_rd  <= 1'b0;
            ack[gnt]  <= 1'b1;
            tcnt      <= '0;
            state     <= WAIT;
          end else if (!rd_vec[gnt]) begin
            sdram_rd  <= 1'b0;
            state     <= IDLE;
          end
        end
        WAIT: begin
          tcnt <= tcnt + TOUT_W'(1);
          if (sdram_rdy) begin
            data_read <= sdram_dout;
            rdy[gnt]  <= 1'b1;
            state     <= DONE;
          end else if (tcnt == TOUT_LAST) begin
            timeout   <= 1'b1;
            ptr       <= gnt + 2'd1;
            state     <= IDLE;
          end
        end
        DONE: begin
          rd_cnt <= sat_inc(rd_cnt);
          ptr    <= gnt + 2'd1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtsdram_rdarb.sv
// Bench for jtsdram_rdarb: scripted requesters, a queued controller responder and
// a negedge monitor that pops expected grants/acks/rdys from scoreboards.
module tb_jtsdram_rdarb;

  localparam int TW = 4;
  localparam int CW = 2;
  localparam logic [CW-1:0] CMAX = '1;

  typedef struct {
    int          ch;
    logic [21:0] addr;
    logic [31:0] data;
  } txn_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [21:0]   addr [4];
  logic [3:0]    rd = 4'd0;
  logic          ba0_ack, ba1_ack, ba2_ack, ba3_ack;
  logic          ba0_rdy, ba1_rdy, ba2_rdy, ba3_rdy;
  logic [3:0]    ackv, rdyv;
  logic [21:0]   sdram_addr;
  logic [1:0]    sdram_ba;
  logic          sdram_rd;
  logic          sdram_ack = 1'b0;
  logic          sdram_rdy = 1'b0;
  logic [31:0]   sdram_dout = 32'd0;
  logic [31:0]   data_read;
  logic          rfsh_req = 1'b0;
  logic          rfsh_ok;
  logic          timeout;
  logic [CW-1:0] rd_cnt;

  int n_cmp = 0;
  int n_err = 0;

  txn_t        gq[$];
  int          aq[$];
  txn_t        rq[$];
  logic [31:0] dq[$];
  logic [CW-1:0] exp_cnt = '0;
  bit          cnt_pend = 1'b0;
  bit          resp_en = 1'b1;
  bit          no_rdy = 1'b0;
  int          ack_dly = 1;
  int          rdy_dly = 2;

  always #5 clk = ~clk;

  assign ackv = {ba3_ack, ba2_ack, ba1_ack, ba0_ack};
  assign rdyv = {ba3_rdy, ba2_rdy, ba1_rdy, ba0_rdy};

  jtsdram_rdarb #(.TOUT_W(TW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .ba0_addr(addr[0]), .ba1_addr(addr[1]), .ba2_addr(addr[2]), .ba3_addr(addr[3]),
    .ba0_rd(rd[0]), .ba1_rd(rd[1]), .ba2_rd(rd[2]), .ba3_rd(rd[3]),
    .ba0_ack(ba0_ack), .ba1_ack(ba1_ack), .ba2_ack(ba2_ack), .ba3_ack(ba3_ack),
    .ba0_rdy(ba0_rdy), .ba1_rdy(ba1_rdy), .ba2_rdy(ba2_rdy), .ba3_rdy(ba3_rdy),
    .sdram_addr(sdram_addr), .sdram_ba(sdram_ba), .sdram_rd(sdram_rd),
    .sdram_ack(sdram_ack), .sdram_rdy(sdram_rdy), .sdram_dout(sdram_dout),
    .data_read(data_read), .rfsh_req(rfsh_req), .rfsh_ok(rfsh_ok),
    .timeout(timeout), .rd_cnt(rd_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_txn(input int ch, input logic [21:0] a, input logic [31:0] d, input bit has_rdy);
    txn_t t;
    t.ch = ch; t.addr = a; t.data = d;
    gq.push_back(t);
    aq.push_back(ch);
    if (has_rdy) begin
      rq.push_back(t);
      dq.push_back(d);
    end
  endtask

  task automatic wait_pulse(input int ch, input bit want_rdy, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (want_rdy ? rdyv[ch] : ackv[ch]) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, seen, 1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    rd = 4'd0;
    rfsh_req = 1'b0;
    repeat (2) @(negedge clk);
    exp_cnt = '0;
    rst = 1'b1;
  endtask

  // Controller model: acks each new request, then returns the next queued data word.
  initial begin
    forever begin
      @(negedge clk);
      if (resp_en && sdram_rd) begin
        repeat (ack_dly) @(negedge clk);
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        if (!no_rdy) begin
          repeat (rdy_dly) @(negedge clk);
          sdram_dout = (dq.size() > 0) ? dq.pop_front() : 32'h0;
          sdram_rdy = 1'b1;
          @(negedge clk);
          sdram_rdy = 1'b0;
        end
      end
    end
  end

  // Monitor: every grant, ack and rdy must match the head of its scoreboard.
  initial begin
    bit   prev_rd;
    txn_t e;
    int   c;
    prev_rd = 1'b0;
    forever begin
      @(negedge clk);
      if (cnt_pend) begin
        chk("rd_cnt", rd_cnt, exp_cnt);
        cnt_pend = 1'b0;
      end
      if (sdram_rd && !prev_rd) begin
        if (gq.size() == 0) chk("gnt_unexp", sdram_rd, 0);
        else begin
          e = gq.pop_front();
          chk("gnt_ba", sdram_ba, e.ch);
          chk("gnt_addr", sdram_addr, e.addr);
        end
      end
      prev_rd = sdram_rd;
      if (ackv != 4'd0) begin
        if (aq.size() == 0) chk("ack_unexp", ackv, 0);
        else begin
          c = aq.pop_front();
          chk("ack_ch", ackv, 4'b0001 << c);
        end
      end
      if (rdyv != 4'd0) begin
        if (rq.size() == 0) chk("rdy_unexp", rdyv, 0);
        else begin
          e = rq.pop_front();
          chk("rdy_ch", rdyv, 4'b0001 << e.ch);
          chk("rdy_data", data_read, e.data);
          if (exp_cnt != CMAX) exp_cnt = exp_cnt + 1'b1;
          cnt_pend = 1'b1;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) addr[i] = 22'd0;
    repeat (2) @(negedge clk);
    chk("rst_sdram_rd", sdram_rd, 0);
    chk("rst_sdram_addr", sdram_addr, 0);
    chk("rst_sdram_ba", sdram_ba, 0);
    chk("rst_ackrdy", {ackv, rdyv}, 0);
    chk("rst_data", data_read, 0);
    chk("rst_flags", {rfsh_ok, timeout}, 0);
    chk("rst_cnt", rd_cnt, 0);
    rst = 1'b1;

    // Single requester on bank 2
    ack_dly = 2; rdy_dly = 3;
    addr[2] = 22'h1234;
    rd[2] = 1'b1;
    push_txn(2, 22'h1234, 32'hCAFEF00D, 1);
    @(negedge clk);
    chk("t1_rd_lat", sdram_rd, 1);
    wait_pulse(2, 1, "t1_rdy_seen");
    chk("t1_data", data_read, 32'hCAFEF00D);
    rd[2] = 1'b0;
    @(negedge clk);
    chk("t1_cnt", rd_cnt, 1);
    repeat (3) @(negedge clk);

    // All four requesters held high: two full rounds in order 0..3
    do_reset();
    ack_dly = 1; rdy_dly = 2;
    for (int i = 0; i < 4; i++) addr[i] = 22'h100 + 22'(i * 3);
    for (int k = 0; k < 8; k++)
      push_txn(k % 4, 22'h100 + 22'((k % 4) * 3), 32'hD000_0000 + 32'(k), 1);
    rd = 4'hF;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      #1;
      if (rq.size() == 0) break;
    end
    rd = 4'h0;
    chk("t2_rq_drained", rq.size(), 0);
    repeat (2) @(negedge clk);
    chk("t2_cnt_sat", rd_cnt, 3);

    // Refresh request raised while bank 1 waits for data
    do_reset();
    rdy_dly = 6;
    addr[1] = 22'h2AAAA;
    addr[3] = 22'h3C3C3;
    push_txn(1, 22'h2AAAA, 32'h1111_2222, 1);
    rd[1] = 1'b1;
    wait_pulse(1, 0, "t3_ack_seen");
    rfsh_req = 1'b1;
    wait_pulse(1, 1, "t3_rdy_seen");
    rd[1] = 1'b0;
    rd[3] = 1'b1;
    @(negedge clk);
    chk("t3_rfsh_ok_lo", rfsh_ok, 0);
    @(negedge clk);
    chk("t3_rfsh_ok_hi", rfsh_ok, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_blocked", sdram_rd, 0);
    end
    rfsh_req = 1'b0;
    push_txn(3, 22'h3C3C3, 32'h3333_4444, 1);
    @(negedge clk);
    chk("t3_rfsh_ok_fall", rfsh_ok, 0);
    chk("t3_resume", sdram_rd, 1);
    wait_pulse(3, 1, "t3_rdy3_seen");
    rd[3] = 1'b0;
    repeat (3) @(negedge clk);

    // Controller never answers bank 0: timeout, then bank 1 gets the port
    no_rdy = 1'b1;
    rdy_dly = 2;
    addr[0] = 22'h00ABC;
    addr[1] = 22'h00DEF;
    push_txn(0, 22'h00ABC, 32'h0, 0);
    push_txn(1, 22'h00DEF, 32'h5555_AAAA, 1);
    rd[0] = 1'b1; rd[1] = 1'b1;
    wait_pulse(0, 0, "t4_ack_seen");
    begin
      int n;
      n = 0;
      while (!timeout && n < 60) begin
        @(negedge clk);
        n++;
      end
      chk("t4_tout_cycles", n, 15);
    end
    rd[0] = 1'b0;
    no_rdy = 1'b0;
    wait_pulse(1, 1, "t4_next_rdy");
    rd[1] = 1'b0;
    repeat (4) @(negedge clk);
    chk("t4_sticky", timeout, 1);

    // Abort in REQ, pointer must stay on bank 0
    do_reset();
    chk("t5_tout_clr", timeout, 0);
    resp_en = 1'b0;
    addr[0] = 22'h0F00F;
    push_txn(0, 22'h0F00F, 32'h0, 0);
    void'(aq.pop_back());
    rd[0] = 1'b1;
    @(negedge clk);
    chk("t5_req", sdram_rd, 1);
    rd[0] = 1'b0;
    @(negedge clk);
    chk("t5_abort", sdram_rd, 0);
    repeat (3) @(negedge clk);
    resp_en = 1'b1;
    addr[1] = 22'h1F1F1;
    push_txn(0, 22'h0F00F, 32'h0BAD_0000, 1);
    push_txn(1, 22'h1F1F1, 32'h0BAD_0001, 1);
    rd[0] = 1'b1; rd[1] = 1'b1;
    wait_pulse(0, 1, "t5_rdy0");
    rd[0] = 1'b0;
    wait_pulse(1, 1, "t5_rdy1");
    rd[1] = 1'b0;
    repeat (3) @(negedge clk);

    // Async reset while bank 2 is in WAIT
    no_rdy = 1'b1;
    addr[2] = 22'h22222;
    push_txn(2, 22'h22222, 32'h0, 0);
    rd[2] = 1'b1;
    wait_pulse(2, 0, "t6_ack_seen");
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t6_sdram", {sdram_rd, sdram_ba, sdram_addr}, 0);
    chk("t6_ackrdy", {ackv, rdyv}, 0);
    chk("t6_data", data_read, 0);
    chk("t6_cnt", rd_cnt, 0);
    chk("t6_flags", {rfsh_ok, timeout}, 0);
    rd = 4'd0;
    exp_cnt = '0;
    no_rdy = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_idle", sdram_rd, 0);
    chk("end_gq", gq.size(), 0);
    chk("end_aq", aq.size(), 0);
    chk("end_rq", rq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/jtsdram_rdarb.md
Name: jtsdram_rdarb

Overview:
- Round-robin arbiter sharing one SDRAM read port among the four bank checker channels (ba0..ba3).
- Serialises read requests, routes ack/rdy back to the winning channel and latches read data.
- Enforces a rdy timeout and blocks new grants while refresh is requested.
- Sits between the checker banks and the SDRAM controller's single read interface.

Parameters:
TOUT_W, 8, width of rdy-timeout counter; timeout fires after 2^TOUT_W-1 cycles waiting for rdy.
CNT_W, 16, width of completed-read counter (saturating).

Ports:
clk  in  1  system clock.
rst  in  1  reset, asynchronous, active-low.
ba0_addr..ba3_addr  in  22 each  requester addresses.
ba0_rd..ba3_rd  in  1 each  read request; held high until own rdy.
ba0_ack..ba3_ack  out  1 each  one-cycle pulse: request accepted by SDRAM.
ba0_rdy..ba3_rdy  out  1 each  one-cycle pulse: data_read valid.
sdram_addr  out  22  address to controller.
sdram_ba  out  2  bank of granted requester.
sdram_rd  out  1  read request to controller.
sdram_ack  in  1  controller accepted request.
sdram_rdy  in  1  controller data valid.
sdram_dout  in  32  controller read data.
data_read  out  32  latched read data.
rfsh_req  in  1  refresh window requested.
rfsh_ok  out  1  high when arbiter is idle and rfsh_req is high.
timeout  out  1  sticky: a rdy timeout occurred.
rd_cnt  out  CNT_W  completed reads, saturating.

Behaviour:
- Reset (rst low, async): state IDLE, rr pointer=0, all ack/rdy=0, sdram_rd=0, sdram_addr=0, sdram_ba=0, data_read=0, rfsh_ok=0, timeout=0, rd_cnt=0.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If rfsh_req: no grant; rfsh_ok=1 (registered, next cycle).
  - Otherwise, grant the first asserted rd searching from the rr pointer upward, mod 4.
  - On grant: register sdram_addr=ba<g>_addr, sdram_ba=g, sdram_rd=1; go to REQ.
  - Grant-to-sdram_rd latency is 1 cycle after rd is seen.
- REQ:
  - If ba<g>_rd drops before sdram_ack: sdram_rd=0, return to IDLE (abort, no ack/rdy, pointer unchanged).
  - On sdram_ack: sdram_rd=0, ba<g>_ack pulses 1 cycle (same cycle as registered response, 1 cycle after sdram_ack), clear timeout counter, go to WAIT.
- WAIT:
  - Timeout counter increments each cycle.
  - On sdram_rdy: data_read<=sdram_dout, go to DONE.
  - If the counter reaches all-ones without sdram_rdy: set timeout=1, go to IDLE, no rdy pulse, pointer advances to g+1.
  - sdram_rdy and terminal count in the same cycle: rdy wins, no timeout.
- DONE:
  - ba<g>_rdy=1 for exactly one cycle with data_read stable; rd_cnt increments unless all-ones.
  - Pointer <= g+1 (wraps 3->0); back to IDLE.
  - data_read holds until the next rdy.
- rfsh_req rising while not IDLE does not abort; the transaction completes, then no new grant is issued.
- rfsh_ok falls the cycle after rfsh_req falls.
- Requester rd changes only sampled in IDLE (grant) and REQ (abort). A new request from the same requester after its rdy is eligible only in the next IDLE cycle.
- sdram_ack/sdram_rdy seen in IDLE are ignored.
- timeout clears only on reset.
- Maximum throughput: one read per 4 cycles plus controller latency.

Test Plan:
- Single requester: ba2_rd=1, addr=22'h1234 -> sdram_rd=1 next cycle with sdram_ba=2, sdram_addr=22'h1234. ack after 2 cycles -> ba2_ack pulse. rdy with dout=32'hCAFEF00D -> ba2_rdy pulse, data_read=32'hCAFEF00D, rd_cnt=1.
- All four rd high continuously from reset -> grant order 0,1,2,3,0,...; each requester receives exactly one rdy per round; no other ba*_ack/rdy asserted concurrently.
- rfsh_req=1 while ba1 is in WAIT -> ba1 completes with rdy. rfsh_ok=1 one cycle after IDLE is reached; sdram_rd stays 0 while rfsh_req=1. Deassert rfsh_req -> rfsh_ok=0 next cycle, grant resumes.
- Controller never returns rdy after ack (TOUT_W=4) -> timeout=1 after 15 WAIT cycles, no rdy pulse, next requester granted. Sticky until rst low.
- ba0_rd dropped in REQ before sdram_ack -> sdram_rd=0 next cycle, no ba0_ack/ba0_rdy, pointer stays 0. Async rst low during WAIT -> all outputs 0 immediately.
- CNT_W=2, run 5 reads -> rd_cnt saturates at 3.
